pattern_read_arbiter: RTL

- Shares the single pattern-memory read port between PORTS requesters, e.g. the sprite manager and the tile/background fetch engine.
- Round-robin grant per cycle over a req/gnt handshake; drives a fixed-latency memory.
- A tag pipeline routes each returning word to the requester that issued it.
- Sits between the sprite/tile fetch logic and pattern VRAM.

---
 rtl/pattern_read_arbiter.sv | 95 +++++++++
 1 files changed

// File: rtl/pattern_read_arbiter.sv
// Round-robin arbiter sharing one fixed-latency pattern-memory read port
// between PORTS requesters; a tag pipeline steers each returned word back
// to the requester that issued the read.
module pattern_read_arbiter #(
    parameter int unsigned PORTS   = 2,
    parameter int unsigned ADDR_W  = 13,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned LATENCY = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    clear,
    input  logic [PORTS-1:0]        req,
    input  logic [PORTS*ADDR_W-1:0] req_addr,
    output logic [PORTS-1:0]        gnt,
    output logic [DATA_W-1:0]       rd_data,
    output logic [PORTS-1:0]        rd_avail,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic                    mem_read,
    input  logic [DATA_W-1:0]       mem_data,
    output logic                    busy
);

    localparam int unsigned IDX_W = $clog2(PORTS);

    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   gnt_idx;
    logic [IDX_W-1:0]   scan_idx;
    logic               grant_found;
    logic [ADDR_W-1:0]  port_addr [PORTS];
    logic [LATENCY-1:0] stage_valid;
    logic [IDX_W-1:0]   stage_idx [LATENCY];

    // Unpack the flat address bus into one entry per port.
    for (genvar p = 0; p < PORTS; p++) begin : g_addr
        assign port_addr[p] = req_addr[p*ADDR_W +: ADDR_W];
    end

    // Grant search from rr_ptr upward with wrap; clear suppresses every grant.
    always_comb begin
        gnt         = '0;
        gnt_idx     = '0;
        scan_idx    = '0;
        grant_found = 1'b0;
        for (int unsigned k = 0; k < PORTS; k++) begin
            scan_idx = IDX_W'((32'(rr_ptr) + k) % PORTS);
            if (!grant_found && !clear && req[scan_idx]) begin
                grant_found = 1'b1;
                gnt_idx     = scan_idx;
            end
        end
        if (grant_found) begin
            gnt[gnt_idx] = 1'b1;
        end
        mem_read = grant_found;
        mem_addr = grant_found ? port_addr[gnt_idx] : '0;
    end

    // Route the returning word to the port held in the final tag stage.
    always_comb begin
        rd_avail = '0;
        if (stage_valid[LATENCY-1] && !clear) begin
            rd_avail[stage_idx[LATENCY-1]] = 1'b1;
        end
        rd_data = mem_data;
        busy    = |stage_valid;
    end

    // Round-robin pointer and first tag stage; reset and clear both flush.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            rr_ptr         <= '0;
            stage_valid[0] <= 1'b0;
        end else begin
            if (grant_found) begin
                rr_ptr <= (gnt_idx == IDX_W'(PORTS - 1)) ? '0 : gnt_idx + IDX_W'(1);
            end
            stage_valid[0] <= grant_found;
        end
        stage_idx[0] <= gnt_idx;
    end

    // Remaining tag stages follow the memory pipeline one cycle each.
    for (genvar s = 1; s < LATENCY; s++) begin : g_stage
        always_ff @(posedge clock) begin
            if (reset || clear) begin
                stage_valid[s] <= 1'b0;
            end else begin
                stage_valid[s] <= stage_valid[s-1];
            end
            stage_idx[s] <= stage_idx[s-1];
        end
    end

endmodule
